// File: rtl/time_set_ctrl.sv
// Mode/edit controller for the BCD hh:mm:ss counter chain.
// Ports: clk, clr, tick_1hz, key_mode, key_inc, cur_hour, cur_min in;
//   cnt_en, ld, ld_hour, ld_min, blink_hour, blink_min, editing,
//   key_click out. All outputs registered.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int HOLD_CYC  = 500,
  parameter int RPT_CYC   = 200
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  output logic       cnt_en,
  output logic       ld,
  output logic [7:0] ld_hour,
  output logic [7:0] ld_min,
  output logic       blink_hour,
  output logic       blink_min,
  output logic       editing,
  output logic       key_click
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(RPT_CYC + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, inc_q;
  logic [7:0]    eh_q, eh_d;
  logic [7:0]    em_q, em_d;
  logic [TW-1:0] to_q, to_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          ph_q, ph_d;

  logic          cnt_d, ld_d, click_d;
  logic [7:0]    ldh_d, ldm_d;
  logic          ed_d, bh_d, bm_d;

  logic          mode_edge, inc_edge;
  logic          rpt_evt, inc_evt;

  // Units above 9 (invalid input) still wrap with a carry.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] maxv
  );
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (v == maxv)
      return 8'h00;
    if (u >= 4'd9)
      return {t + 4'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  assign mode_edge = key_mode & ~mode_q;
  assign inc_edge  = key_inc & ~inc_q;

  // Hold counter saturates at HOLD_CYC; the repeat
  // counter then runs and fires every RPT_CYC cycles.
  always_comb begin
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    rpt_evt = 1'b0;
    if (!key_inc) begin
      hold_d = '0;
      rpt_d  = '0;
    end else if (hold_q != HW'(HOLD_CYC)) begin
      hold_d  = hold_q + HW'(1);
      rpt_evt = (hold_d == HW'(HOLD_CYC));
    end else begin
      rpt_d = rpt_q + RW'(1);
      if (rpt_d == RW'(RPT_CYC)) begin
        rpt_evt = 1'b1;
        rpt_d   = '0;
      end
    end
  end

  assign inc_evt = inc_edge | rpt_evt;

  always_comb begin
    state_d = state_q;
    eh_d    = eh_q;
    em_d    = em_q;
    to_d    = to_q;
    ph_d    = tick_1hz ? ~ph_q : ph_q;
    cnt_d   = 1'b0;
    ld_d    = 1'b0;
    ldh_d   = ld_hour;
    ldm_d   = ld_min;
    click_d = 1'b0;
    unique case (state_q)
      RUN: begin
        cnt_d = tick_1hz;
        if (mode_edge) begin
          eh_d    = cur_hour;
          em_d    = cur_min;
          state_d = SET_HOUR;
          to_d    = '0;
          ph_d    = 1'b1;
          click_d = 1'b1;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (mode_edge) begin
          to_d    = '0;
          click_d = 1'b1;
          if (state_q == SET_HOUR) begin
            state_d = SET_MIN;
            ph_d    = 1'b1;
          end else begin
            state_d = COMMIT;
            ld_d    = 1'b1;
            ldh_d   = eh_q;
            ldm_d   = em_q;
          end
        end else if (inc_evt) begin
          to_d    = '0;
          click_d = 1'b1;
          if (state_q == SET_HOUR)
            eh_d = bcd_inc(eh_q, 8'h23);
          else
            em_d = bcd_inc(em_q, 8'h59);
        end else if (tick_1hz) begin
          if (to_q == TW'(TIMEOUT_S - 1)) begin
            state_d = RUN;
            to_d    = '0;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end
      COMMIT: begin
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    ed_d = (state_d == SET_HOUR) ||
           (state_d == SET_MIN);
    bh_d = (state_d == SET_HOUR) & ph_d;
    bm_d = (state_d == SET_MIN) & ph_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= RUN;
      mode_q     <= 1'b0;
      inc_q      <= 1'b0;
      eh_q       <= 8'h00;
      em_q       <= 8'h00;
      to_q       <= '0;
      hold_q     <= '0;
      rpt_q      <= '0;
      ph_q       <= 1'b0;
      cnt_en     <= 1'b0;
      ld         <= 1'b0;
      ld_hour    <= 8'h00;
      ld_min     <= 8'h00;
      blink_hour <= 1'b0;
      blink_min  <= 1'b0;
      editing    <= 1'b0;
      key_click  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= key_mode;
      inc_q      <= key_inc;
      eh_q       <= eh_d;
      em_q       <= em_d;
      to_q       <= to_d;
      hold_q     <= hold_d;
      rpt_q      <= rpt_d;
      ph_q       <= ph_d;
      cnt_en     <= cnt_d;
      ld         <= ld_d;
      ld_hour    <= ldh_d;
      ld_min     <= ldm_d;
      blink_hour <= bh_d;
      blink_min  <= bm_d;
      editing    <= ed_d;
      key_click  <= click_d;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed-vector bench for time_set_ctrl.
// Ports driven after posedge, outputs sampled 1 time unit later.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       tick_1hz;
  logic       key_mode;
  logic       key_inc;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic       cnt_en;
  logic       ld;
  logic [7:0] ld_hour;
  logic [7:0] ld_min;
  logic       blink_hour;
  logic       blink_min;
  logic       editing;
  logic       key_click;

  int n_vec = 0;
  int n_bad = 0;

  time_set_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .tick_1hz   (tick_1hz),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cnt_en     (cnt_en),
    .ld         (ld),
    .ld_hour    (ld_hour),
    .ld_min     (ld_min),
    .blink_hour (blink_hour),
    .blink_min  (blink_min),
    .editing    (editing),
    .key_click  (key_click)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_o();
    return {10'd0, cnt_en, ld, ld_hour, ld_min,
            blink_hour, blink_min, editing,
            key_click};
  endfunction

  task automatic press_mode(input string tag);
    key_mode = 1'b1;
    cyc();
    chk({tag, ".click"}, 32'(key_click), 32'd1);
    key_mode = 1'b0;
    cyc();
  endtask

  task automatic press_inc(input string tag);
    key_inc = 1'b1;
    cyc();
    chk({tag, ".click"}, 32'(key_click), 32'd1);
    key_inc = 1'b0;
    cyc();
  endtask

  int pulses;
  int clicks[$];
  int exp_at[4] = '{1, 500, 700, 900};

  initial begin
    clr = 1'b1;
    tick_1hz = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    cur_hour = 8'h23;
    cur_min  = 8'h58;
    cyc();
    cyc();
    chk("reset.outs", all_o(), 32'd0);
    clr = 1'b0;
    cyc();

    // 5 ticks in RUN
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      if (cnt_en) pulses++;
      cyc();
      if (cnt_en) pulses += 100;
      cyc();
    end
    chk("run.cnt_en", pulses, 5);
    chk("run.idle", all_o(), 32'd0);

    // 23:58 -> edit to 00:00
    press_mode("e1.m1");
    chk("e1.sethour",
        {editing, blink_hour, blink_min}, 3'b110);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    chk("e1.frozen", 32'(cnt_en), 32'd0);
    cyc();
    press_inc("e1.i1");
    press_mode("e1.m2");
    chk("e1.setmin",
        {editing, blink_hour, blink_min}, 3'b101);
    press_inc("e1.i2");
    press_inc("e1.i3");
    key_mode = 1'b1;
    cyc();
    chk("e1.commit",
        {ld, ld_hour, ld_min, editing, cnt_en},
        {1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    key_mode = 1'b0;
    cyc();
    chk("e1.ld_drop", 32'(ld), 32'd0);

    // auto-repeat from 07:09
    cur_hour = 8'h07;
    cur_min  = 8'h09;
    press_mode("e2.m1");
    press_mode("e2.m2");
    key_inc = 1'b1;
    for (int i = 1; i <= 1050; i++) begin
      cyc();
      if (key_click) clicks.push_back(i);
    end
    key_inc = 1'b0;
    chk("e2.nclicks", clicks.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("e2.at%0d", k),
          k < clicks.size() ? clicks[k] : -1,
          exp_at[k]);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (key_click) pulses++;
    end
    chk("e2.released", pulses, 0);
    key_mode = 1'b1;
    cyc();
    chk("e2.commit", {ld, ld_hour, ld_min},
        {1'b1, 8'h07, 8'h13});
    key_mode = 1'b0;
    cyc();

    // timeout after 10 silent ticks
    cur_hour = 8'h12;
    cur_min  = 8'h34;
    press_mode("e3.m1");
    pulses = 0;
    for (int t = 1; t <= 10; t++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      if (t == 1)
        chk("e3.blink_off", 32'(blink_hour), 32'd0);
      if (t == 9)
        chk("e3.still_edit", 32'(editing), 32'd1);
      if (t == 10)
        chk("e3.timeout",
            {editing, blink_hour, cnt_en}, 3'b000);
      if (ld) pulses++;
      cyc();
      if (ld) pulses++;
      cyc();
    end
    chk("e3.no_ld", pulses, 0);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    chk("e3.resume", 32'(cnt_en), 32'd1);
    cyc();

    // mode + inc together: mode wins
    cur_hour = 8'h19;
    cur_min  = 8'h30;
    press_mode("e4.m1");
    key_mode = 1'b1;
    key_inc  = 1'b1;
    cyc();
    chk("e4.both",
        {blink_hour, blink_min, key_click}, 3'b011);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    cyc();
    key_mode = 1'b1;
    cyc();
    chk("e4.commit", {ld, ld_hour, ld_min},
        {1'b1, 8'h19, 8'h30});
    key_mode = 1'b0;
    cyc();

    // 19 -> 20 carry
    press_mode("e5.m1");
    press_inc("e5.i1");
    press_mode("e5.m2");
    key_mode = 1'b1;
    cyc();
    chk("e5.commit", {ld, ld_hour, ld_min},
        {1'b1, 8'h20, 8'h30});
    key_mode = 1'b0;
    cyc();

    // clr mid-edit with key_inc held
    press_mode("e6.m1");
    press_mode("e6.m2");
    key_inc = 1'b1;
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    chk("e6.clr", all_o(), 32'd0);
    clr = 1'b0;
    cyc();
    chk("e6.inc_ign",
        {editing, key_click, ld}, 3'b000);
    key_inc = 1'b0;
    cyc();
    press_mode("e6.m3");
    chk("e6.reenter", 32'(editing), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
